// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// The pointer-width helper adds one wrap bit that tells full apart from empty.
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the FIFO: one synchronous write port and one registered read port.
// The read register is cleared by reset. The array contents are not.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int depth = DEFAULT_DEPTH,
    parameter int aw    = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_re,
    input  logic [aw-1:0]    i_raddr,
    output logic [width-1:0] o_rdata
);

    logic [width-1:0] r_mem [depth];
    logic [width-1:0] r_rdata;

    // NOTE: the storage array gets no reset, so it can map onto plain RAM.
    // Stale words are never visible, because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and combinational full/empty flags.
// The pointer and flag logic live here. Storage is in sync_fifo_mem.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int depth = DEFAULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic             r_en,
    input  logic [width-1:0] data_in,
    output logic [width-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_width(depth);
    localparam int AW = PW - 1;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          w_wr_acc;
    logic          w_rd_acc;

    assign w_wr_acc = w_en && !full;
    assign w_rd_acc = r_en && !empty;

    // The pointers are equal when the FIFO is empty.
    // Equal indexes with different wrap bits mean the FIFO is full.
    assign empty = (r_rptr == r_wptr);
    assign full  = (r_rptr[AW-1:0] == r_wptr[AW-1:0]) && (r_rptr[AW] != r_wptr[AW]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    sync_fifo_mem #(
        .width (width),
        .depth (depth),
        .aw    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (data_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed and random stimulus checked against a queue model.
// A separate monitor compares each word read from the DUT with the expected value from the scoreboard.
module tb_sync_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             w_en = 1'b0;
    logic             r_en = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] exp_last = '0;

    sync_fifo #(.width(WIDTH), .depth(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: data_out must equal the most recent word read by the model.
    always @(negedge clk) begin
        if (rst) begin
            if (sb_q.size() > 0) begin
                exp_last = sb_q.pop_front();
            end
            check("data_out", 32'(data_out), 32'(exp_last));
        end
    end

    task automatic check_flags(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
    endtask

    // One clock of stimulus. The model decides acceptance from its own occupancy before the edge.
    task automatic op(input logic we, input logic re, input logic [WIDTH-1:0] din);
        bit acc_w;
        bit acc_r;
        w_en    = we;
        r_en    = re;
        data_in = din;
        acc_w   = we && (model_q.size() < DEPTH);
        acc_r   = re && (model_q.size() > 0);
        @(posedge clk);
        if (acc_r) begin
            sb_q.push_back(model_q.pop_front());
        end
        if (acc_w) begin
            model_q.push_back(din);
        end
        #1;
        check_flags("op");
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_q.delete();
        sb_q.delete();
        exp_last = '0;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        #14;
        rst = 1'b1;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        op(1'b0, 1'b0, '0);
        op(1'b0, 1'b1, '0);
        check("post_rst_dout", 32'(data_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        do_reset();

        // Fill, overflow, drain, underflow
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, WIDTH'(i));
        check("fill_full", 32'(full), 32'd1);
        op(1'b1, 1'b0, 4'hA);
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, '0);
        check("drain_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) op(1'b0, 1'b1, '0);
        check("underflow_hold", 32'(data_out), 32'hF);

        // Wrap-around
        for (int i = 0; i < 10; i++) op(1'b1, 1'b0, WIDTH'(i + 3));
        for (int i = 0; i < 10; i++) op(1'b0, 1'b1, '0);
        for (int i = 1; i <= 12; i++) op(1'b1, 1'b0, WIDTH'(i));
        for (int i = 0; i < 12; i++) op(1'b0, 1'b1, '0);

        // Simultaneous read/write at occupancy 5, at full, and at empty
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, WIDTH'(i + 8));
        for (int i = 0; i < 6; i++) op(1'b1, 1'b1, WIDTH'(i));
        check("occ5_kept", 32'(model_q.size()), 32'd5);
        while (model_q.size() < DEPTH) op(1'b1, 1'b0, 4'h3);
        op(1'b1, 1'b1, 4'hE);
        check("full_rw_clears", 32'(full), 32'd0);
        while (model_q.size() > 0) op(1'b0, 1'b1, '0);
        op(1'b1, 1'b1, 4'h7);
        check("empty_rw_notempty", 32'(empty), 32'd0);
        op(1'b0, 1'b1, '0);
        check("empty_rw_read7", 32'(data_out), 32'h7);

        // Latency: the word is visible right after the read edge
        op(1'b1, 1'b0, 4'h5);
        op(1'b0, 1'b1, '0);
        check("lat_dout", 32'(data_out), 32'h5);
        check("lat_empty", 32'(empty), 32'd1);

        // Mid-run reset
        for (int i = 0; i < 7; i++) op(1'b1, 1'b0, WIDTH'(i + 2));
        op(1'b0, 1'b1, '0);
        do_reset();

        // Random traffic with phases biased toward filling and toward draining
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 100) % 2 == 0) ? 75 : 30;
            op(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < (100 - wp)),
               WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
        end

        op(1'b0, 1'b0, '0);
        op(1'b0, 1'b0, '0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
